// File: rtl/riscv_mem_arbiter.sv
//------------------------------------------------------------------------------
// riscv_mem_arbiter
//
// Purpose:
//   Shares one block-wide memory port between the instruction cache (refill
//   reads only) and the data cache (write-backs and refills).  A three-state
//   FSM (IDLE / GNT_I / GNT_D) grants one requester at a time.  The shared
//   port address, write data and strobes are registered on the grant edge and
//   held for the whole transaction.  Completion is signalled combinationally
//   back to the granted requester in the cycle the memory reports ready.
//
// Configuration:
//   RISCV_ARB_ROUND_ROBIN_EN  defined   : simultaneous requests are resolved
//                                         with a 1-bit last-grant register
//                                         (reset value = icache).
//                             undefined : the dcache always wins a tie.
//
// Ports:
//   i_riscv_arb_clk            clock, rising edge
//   i_riscv_arb_rst            asynchronous active-low reset
//   i_riscv_arb_imem_rden      icache refill request (held until ready)
//   i_riscv_arb_imem_addr      icache block address
//   o_riscv_arb_imem_ready     icache completion pulse
//   o_riscv_arb_imem_data_out  icache refill data (0 unless ready)
//   i_riscv_arb_dmem_wren      dcache write-back request
//   i_riscv_arb_dmem_rden      dcache refill request
//   i_riscv_arb_dmem_addr      dcache block address
//   i_riscv_arb_dmem_data_in   dcache write-back data
//   o_riscv_arb_dmem_ready     dcache completion pulse
//   o_riscv_arb_dmem_data_out  dcache refill data (0 unless ready)
//   o_riscv_arb_mem_wren       shared port write strobe
//   o_riscv_arb_mem_rden       shared port read strobe
//   o_riscv_arb_mem_addr       shared port block address
//   o_riscv_arb_mem_data_in    shared port write data
//   i_riscv_arb_mem_ready      shared port completion
//   i_riscv_arb_mem_data_out   shared port read data
//------------------------------------------------------------------------------
module riscv_mem_arbiter #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned S_ADDR     = 23
) (
   input  logic                  i_riscv_arb_clk,
   input  logic                  i_riscv_arb_rst,
   // icache side
   input  logic                  i_riscv_arb_imem_rden,
   input  logic [S_ADDR-1:0]     i_riscv_arb_imem_addr,
   output logic                  o_riscv_arb_imem_ready,
   output logic [DATA_WIDTH-1:0] o_riscv_arb_imem_data_out,
   // dcache side
   input  logic                  i_riscv_arb_dmem_wren,
   input  logic                  i_riscv_arb_dmem_rden,
   input  logic [S_ADDR-1:0]     i_riscv_arb_dmem_addr,
   input  logic [DATA_WIDTH-1:0] i_riscv_arb_dmem_data_in,
   output logic                  o_riscv_arb_dmem_ready,
   output logic [DATA_WIDTH-1:0] o_riscv_arb_dmem_data_out,
   // shared memory port
   output logic                  o_riscv_arb_mem_wren,
   output logic                  o_riscv_arb_mem_rden,
   output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
   output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_data_in,
   input  logic                  i_riscv_arb_mem_ready,
   input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_data_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic icache_req;
   logic dcache_req;
   logic pick_d;
   logic grant_i;
   logic grant_d;
   logic done;
   logic armed;

   assign icache_req = i_riscv_arb_imem_rden;
   assign dcache_req = i_riscv_arb_dmem_wren | i_riscv_arb_dmem_rden;

   // Arbitration is only evaluated from IDLE, so pick_d merely says which
   // requester would win if a grant is taken this cycle.
`ifdef RISCV_ARB_ROUND_ROBIN_EN
   logic last_d;

   // On a tie, serve whoever was not served last.
   always_comb begin
      pick_d = dcache_req & (~icache_req | ~last_d);
   end

   always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst) begin
      if (!i_riscv_arb_rst) begin
         last_d <= 1'b0;
      end else if (grant_d) begin
         last_d <= 1'b1;
      end else if (grant_i) begin
         last_d <= 1'b0;
      end
   end
`else
   always_comb begin
      pick_d = dcache_req;
   end
`endif

   // The first cycle after reset release only arms the arbiter, so the
   // earliest grant lands on the second rising edge.
   always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst) begin
      if (!i_riscv_arb_rst) begin
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
      end
   end

   always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst) begin
      if (!i_riscv_arb_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Every completion returns to IDLE, which forces a one-cycle gap between
   // consecutive grants.
   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (armed) begin
               if (pick_d) begin
                  state_next = GNT_D;
                  grant_d    = 1'b1;
               end else if (icache_req) begin
                  state_next = GNT_I;
                  grant_i    = 1'b1;
               end
            end
         end
         GNT_I, GNT_D: begin
            if (i_riscv_arb_mem_ready) begin
               state_next = IDLE;
               done       = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Shared port registers: loaded only on the grant edge so requester input
   // changes during a grant cannot disturb the memory. A dcache request with
   // both wren and rden is issued as the write; the read re-arbitrates later.
   always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst) begin
      if (!i_riscv_arb_rst) begin
         o_riscv_arb_mem_wren    <= 1'b0;
         o_riscv_arb_mem_rden    <= 1'b0;
         o_riscv_arb_mem_addr    <= '0;
         o_riscv_arb_mem_data_in <= '0;
      end else if (grant_d) begin
         o_riscv_arb_mem_wren    <= i_riscv_arb_dmem_wren;
         o_riscv_arb_mem_rden    <= i_riscv_arb_dmem_rden & ~i_riscv_arb_dmem_wren;
         o_riscv_arb_mem_addr    <= i_riscv_arb_dmem_addr;
         o_riscv_arb_mem_data_in <= i_riscv_arb_dmem_data_in;
      end else if (grant_i) begin
         o_riscv_arb_mem_wren    <= 1'b0;
         o_riscv_arb_mem_rden    <= 1'b1;
         o_riscv_arb_mem_addr    <= i_riscv_arb_imem_addr;
         o_riscv_arb_mem_data_in <= '0;
      end else if (done) begin
         o_riscv_arb_mem_wren    <= 1'b0;
         o_riscv_arb_mem_rden    <= 1'b0;
      end
   end

   // Completion is combinational so the requester sees it in the same cycle
   // as the memory; data is gated to zero outside the pulse.
   always_comb begin
      o_riscv_arb_imem_ready    = (state == GNT_I) & i_riscv_arb_mem_ready;
      o_riscv_arb_dmem_ready    = (state == GNT_D) & i_riscv_arb_mem_ready;
      o_riscv_arb_imem_data_out = '0;
      o_riscv_arb_dmem_data_out = '0;
      if (o_riscv_arb_imem_ready) begin
         o_riscv_arb_imem_data_out = i_riscv_arb_mem_data_out;
      end
      if (o_riscv_arb_dmem_ready) begin
         o_riscv_arb_dmem_data_out = i_riscv_arb_mem_data_out;
      end
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
//------------------------------------------------------------------------------
// tb_riscv_mem_arbiter
//
// Self-checking bench for riscv_mem_arbiter.  Each scenario pushes the grants
// it expects into a scoreboard queue; the memory responder task pops them as
// strobes appear and compares the shared-port contents and the completion
// handshake.  Expectations for simultaneous requests follow
// RISCV_ARB_ROUND_ROBIN_EN when the bench is built with it.
//------------------------------------------------------------------------------
module tb_riscv_mem_arbiter;

   localparam int DW = 128;
   localparam int AW = 23;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          imem_rden = 1'b0;
   logic [AW-1:0] imem_addr = '0;
   logic          imem_ready;
   logic [DW-1:0] imem_data_out;
   logic          dmem_wren = 1'b0;
   logic          dmem_rden = 1'b0;
   logic [AW-1:0] dmem_addr = '0;
   logic [DW-1:0] dmem_data_in = '0;
   logic          dmem_ready;
   logic [DW-1:0] dmem_data_out;
   logic          mem_wren;
   logic          mem_rden;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_data_out = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit            is_d;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   riscv_mem_arbiter #(
      .DATA_WIDTH(DW),
      .S_ADDR    (AW)
   ) dut (
      .i_riscv_arb_clk          (clk),
      .i_riscv_arb_rst          (rst_n),
      .i_riscv_arb_imem_rden    (imem_rden),
      .i_riscv_arb_imem_addr    (imem_addr),
      .o_riscv_arb_imem_ready   (imem_ready),
      .o_riscv_arb_imem_data_out(imem_data_out),
      .i_riscv_arb_dmem_wren    (dmem_wren),
      .i_riscv_arb_dmem_rden    (dmem_rden),
      .i_riscv_arb_dmem_addr    (dmem_addr),
      .i_riscv_arb_dmem_data_in (dmem_data_in),
      .o_riscv_arb_dmem_ready   (dmem_ready),
      .o_riscv_arb_dmem_data_out(dmem_data_out),
      .o_riscv_arb_mem_wren     (mem_wren),
      .o_riscv_arb_mem_rden     (mem_rden),
      .o_riscv_arb_mem_addr     (mem_addr),
      .o_riscv_arb_mem_data_in  (mem_data_in),
      .i_riscv_arb_mem_ready    (mem_ready),
      .i_riscv_arb_mem_data_out (mem_data_out)
   );

   function automatic logic [DW-1:0] resp_data(input logic [AW-1:0] a);
      logic [DW-1:0] salt;
      salt = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      return {4{9'h000, a}} ^ salt;
   endfunction

   function automatic exp_t mk(input bit is_d, input bit wr,
                               input logic [AW-1:0] a, input logic [DW-1:0] w);
      exp_t e;
      e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = w;
      return e;
   endfunction

   // Memory responder: wait (bounded) for a strobe, check it against the
   // scoreboard, hold for lat cycles while jiggling requester inputs, then
   // complete and verify the ready pulse and the idle gap that follows.
   // rel: 0 keep requests, 1 release the completed operation, 2 release all.
   task automatic serve_one(input int lat, input int budget, input int rel, input bit drop);
      exp_t          e;
      bit            found;
      logic [DW-1:0] r;
      logic          gr, ot;
      logic [DW-1:0] gd, od;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (mem_wren || mem_rden) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL grant_timeout: no strobe within %0d cycles, expected one", budget);
         return;
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_grant: got addr %h, expected no grant", mem_addr);
         return;
      end
      e = exp_q.pop_front();
      checks++;
      if (mem_addr !== e.addr || mem_wren !== e.wr || mem_rden !== !e.wr) begin
         errors++;
         $display("FAIL grant: got addr %h wren %b rden %b, expected addr %h wren %b rden %b",
                  mem_addr, mem_wren, mem_rden, e.addr, e.wr, !e.wr);
      end
      if (e.wr) begin
         checks++;
         if (mem_data_in !== e.wdata) begin
            errors++;
            $display("FAIL wdata: got %h, expected %h", mem_data_in, e.wdata);
         end
      end
      if (drop) begin
         if (e.is_d) begin
            dmem_wren = 1'b0;
            dmem_rden = 1'b0;
         end else begin
            imem_rden = 1'b0;
         end
      end
      for (int c = 1; c < lat; c++) begin
         if (c == 1) begin
            imem_addr    = imem_addr ^ 23'h155;
            dmem_addr    = dmem_addr ^ 23'h2AA;
            dmem_data_in = ~dmem_data_in;
         end
         @(negedge clk);
         checks++;
         if (mem_addr !== e.addr || mem_wren !== e.wr || mem_rden !== !e.wr ||
             imem_ready !== 1'b0 || dmem_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold: got addr %h wren %b rden %b rdy %b%b, expected addr %h wren %b rden %b rdy 00",
                     mem_addr, mem_wren, mem_rden, imem_ready, dmem_ready, e.addr, e.wr, !e.wr);
         end
      end
      if (lat > 1) begin
         imem_addr    = imem_addr ^ 23'h155;
         dmem_addr    = dmem_addr ^ 23'h2AA;
         dmem_data_in = ~dmem_data_in;
      end
      r = resp_data(e.addr);
      mem_data_out = r;
      mem_ready    = 1'b1;
      #1;
      if (e.is_d) begin
         gr = dmem_ready; ot = imem_ready; gd = dmem_data_out; od = imem_data_out;
      end else begin
         gr = imem_ready; ot = dmem_ready; gd = imem_data_out; od = dmem_data_out;
      end
      checks++;
      if (gr !== 1'b1 || ot !== 1'b0) begin
         errors++;
         $display("FAIL ready: got granted %b other %b, expected 1 0", gr, ot);
      end
      checks++;
      if (gd !== r || od !== '0) begin
         errors++;
         $display("FAIL data_out: got granted %h other %h, expected %h and 0", gd, od, r);
      end
      if (rel == 2) begin
         imem_rden = 1'b0; dmem_wren = 1'b0; dmem_rden = 1'b0;
      end else if (rel == 1) begin
         if (!e.is_d) imem_rden = 1'b0;
         else if (e.wr) dmem_wren = 1'b0;
         else dmem_rden = 1'b0;
      end
      @(negedge clk);
      mem_ready    = 1'b0;
      mem_data_out = '0;
      #1;
      checks++;
      if (mem_wren !== 1'b0 || mem_rden !== 1'b0 || imem_ready !== 1'b0 || dmem_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_gap: got wren %b rden %b rdy %b%b, expected all 0",
                  mem_wren, mem_rden, imem_ready, dmem_ready);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_wren, mem_rden, imem_ready, dmem_ready} !== 4'b0 || mem_addr !== '0 ||
          mem_data_in !== '0 || imem_data_out !== '0 || dmem_data_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got strobes %b%b addr %h, expected all 0",
                  mem_wren, mem_rden, mem_addr);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (mem_wren !== 1'b0 || mem_rden !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_req: got wren %b rden %b, expected 0 0", mem_wren, mem_rden);
      end
   endtask

   task automatic test_icache_single();
      imem_addr = 23'h000010;
      imem_rden = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 23'h000010, '0));
      serve_one(3, 1, 1, 1'b0);
   endtask

   task automatic test_both_requesting();
      imem_addr = 23'h000100;
      dmem_addr = 23'h000200;
      dmem_rden = 1'b1;
      imem_rden = 1'b1;
      for (int k = 0; k < 4; k++) begin
`ifdef RISCV_ARB_ROUND_ROBIN_EN
         if (k % 2 == 0) exp_q.push_back(mk(1'b1, 1'b0, 23'h000200, '0));
         else            exp_q.push_back(mk(1'b0, 1'b0, 23'h000100, '0));
`else
         exp_q.push_back(mk(1'b1, 1'b0, 23'h000200, '0));
`endif
      end
      for (int k = 0; k < 4; k++) begin
         serve_one(1, 1, (k == 3) ? 2 : 0, 1'b0);
      end
   endtask

   task automatic test_dcache_wr_rd();
      dmem_addr    = 23'h00ABCD;
      dmem_data_in = {16{8'h5A}};
      dmem_wren    = 1'b1;
      dmem_rden    = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b1, 23'h00ABCD, {16{8'h5A}}));
      exp_q.push_back(mk(1'b1, 1'b0, 23'h00ABCD, '0));
      serve_one(2, 1, 1, 1'b0);
      serve_one(2, 1, 1, 1'b0);
   endtask

   task automatic test_drop_and_stray();
      imem_addr = 23'h000077;
      imem_rden = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 23'h000077, '0));
      serve_one(3, 1, 0, 1'b1);
      @(negedge clk);
      mem_data_out = resp_data(23'h1234);
      mem_ready    = 1'b1;
      #1;
      checks++;
      if (imem_ready !== 1'b0 || dmem_ready !== 1'b0 || imem_data_out !== '0 || dmem_data_out !== '0) begin
         errors++;
         $display("FAIL stray_ready: got rdy %b%b, expected 00 with zero data", imem_ready, dmem_ready);
      end
      @(negedge clk);
      mem_ready    = 1'b0;
      mem_data_out = '0;
      checks++;
      if (mem_wren !== 1'b0 || mem_rden !== 1'b0) begin
         errors++;
         $display("FAIL stray_grant: got wren %b rden %b, expected 0 0", mem_wren, mem_rden);
      end
   endtask

   task automatic test_reset_in_grant();
      dmem_addr    = 23'h000333;
      dmem_data_in = {$urandom, $urandom, $urandom, $urandom};
      dmem_wren    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (mem_wren !== 1'b1 || mem_addr !== 23'h000333) begin
         errors++;
         $display("FAIL pre_reset_grant: got wren %b addr %h, expected 1 000333", mem_wren, mem_addr);
      end
      #2;
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({mem_wren, mem_rden, imem_ready, dmem_ready} !== 4'b0 || mem_addr !== '0 ||
          mem_data_in !== '0 || dmem_data_out !== '0) begin
         errors++;
         $display("FAIL async_reset: got strobes %b%b rdy %b%b addr %h, expected all 0",
                  mem_wren, mem_rden, imem_ready, dmem_ready, mem_addr);
      end
      exp_q.delete();
      dmem_wren = 1'b0;
      dmem_rden = 1'b1;
      dmem_addr = 23'h000444;
      imem_rden = 1'b1;
      imem_addr = 23'h000555;
      @(negedge clk);
      mem_ready = 1'b0;
      rst_n     = 1'b1;
      exp_q.push_back(mk(1'b1, 1'b0, 23'h000444, '0));
      exp_q.push_back(mk(1'b0, 1'b0, 23'h000555, '0));
      @(negedge clk);
      checks++;
      if (mem_wren !== 1'b0 || mem_rden !== 1'b0) begin
         errors++;
         $display("FAIL early_grant: got wren %b rden %b one edge after release, expected 0 0",
                  mem_wren, mem_rden);
      end
      serve_one(1, 1, 1, 1'b0);
      serve_one(1, 1, 1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_icache_single();
      test_both_requesting();
      test_dcache_wr_rd();
      test_drop_and_stray();
      test_reset_in_grant();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending grants, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
